i2c_controller: RTL and testbench
=================================

# i2c_controller

I2C master that turns single-cycle write or read requests into complete I2C bus transactions on an open-drain SDA line and a controller-driven SCL line. A 6-bit target address with a R/W bit is sent, then one data byte is written or read. It sits between the host-side request logic and the I2C memory-controller bus.

## Interface
- DATAWIDTH, 8, data byte width
- ADDRWIDTH, 6, target address width
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset
- wr_en  input  1  write request; sampled only in IDLE
- rd_en  input  1  read request; sampled only in IDLE
- data  input  DATAWIDTH  write byte; captured with the request
- addr  input  ADDRWIDTH  target address; captured with the request
- sda  inout  1  open-drain data line: driven 0 or released to 'z', never driven 1 (external pull-up)
- scl  output  1  I2C clock; idles 1

## Operation
- State encoding is fixed because benches probe `state` and `next_state`:
  - 0 IDLE, 1 START, 2 ADDR, 3 RW, 4 WDATA, 5 ACK, 6 RDATA, 7 DACK, 8 MNACK, 9 STOP.
- Registers:
  - state, next_state (combinational)
  - addr_q, data_q, rw_q (1 = read)
  - bit counter; phase bit (0 = SCL low, 1 = SCL high); ack retry counter (2 bits)
  - rd_data_q[7:0], holding the last byte read
  - nack_q flag
- IDLE:
  - If wr_en=1, capture addr/data and set rw_q=0.
  - Else if rd_en=1, capture addr and set rw_q=1.
  - On either, go to START. wr_en has priority when both are high.
- Requests arriving outside IDLE are ignored; there is no queue.
- START: SDA is pulled low while SCL=1 for one cycle, then SCL goes low.
- ADDR: shifts addr_q out MSB first, 6 bits. Then RW sends rw_q.
- Bit slot:
  - Each bit is 2 clk cycles: a SCL=0 cycle, in which SDA is updated, then a SCL=1 cycle, in which SDA is stable and sampled.
  - Bit value 0 pulls SDA low. Bit value 1 releases SDA.
- ACK (address acknowledge):
  - SDA is released and sampled in the SCL=1 phase.
  - If SDA=0, go to WDATA when rw_q=0, or to RDATA when rw_q=1.
  - If SDA=1, repeat the ack slot. After 4 failed slots, set nack_q and go to STOP.
  - next_state stays 5 until SDA is seen low, so a target may pull SDA low while state==next_state==5.
- WDATA: sends data_q MSB first, 8 bits, then DACK.
- DACK: same retry/timeout rule as ACK. On success go to STOP.
- RDATA:
  - SDA is released for 8 bits.
  - Each bit is shifted into rd_data_q MSB first in the SCL=1 phase.
  - Then MNACK: SDA is released for one bit slot (master NACK, single-byte read), then STOP.
- STOP: SDA is held low with SCL=0, then SCL=1, then SDA is released while SCL=1. Then IDLE.
- nack_q clears on the next accepted request.

## Timing
- Reset (async, asserted low) values:
  - state=IDLE, scl=1, SDA released
  - addr_q, data_q, rd_data_q, counters, nack_q all 0
- Reset has immediate effect mid-transaction. The bus returns to idle with no STOP generated.
- Request accept: request high at a rising edge in IDLE gives state=START after that edge.
- Transaction length with immediate ACKs:
  - START 2 + ADDR 12 + RW 2 + ACK 2 + WDATA/RDATA 16 + DACK/MNACK 2 + STOP 2 = 38 cycles.
  - Each ack retry adds 2 cycles.
- IDLE is re-entered after STOP. A new request may be accepted in the first IDLE cycle.
- scl is registered: no glitches, and it is 1 whenever in IDLE.

## Test plan
- Reset: hold reset=0 for 5 cycles -> state=0, scl=1, sda='z' (pull-up reads 1), rd_data_q=0.
- Write with target ACK:
  - Stimulus: addr=6'h2A, data=8'hC5, wr_en pulse; target pulls SDA low whenever state==next_state==5 or DACK.
  - Required: SDA bits on SCL rising are 101010, 0, then 11000101; STOP follows; back in IDLE 38 cycles after accept.
- Read:
  - Stimulus: addr=6'h15, rd_en pulse; target ACKs, then drives 8'h3C in RDATA.
  - Required: RW bit=1; rd_data_q=8'h3C; MNACK slot leaves SDA released; STOP follows.
- No ACK: write to addr=6'h01 with SDA never pulled low -> 4 ack slots, nack_q=1, STOP, IDLE; no data bits sent.
- Busy/priority:
  - Hold wr_en=1 for 10 cycles with addr/data changing each cycle -> exactly one transaction, using the first-cycle values.
  - wr_en=rd_en=1 in the same cycle -> write.
- Reset mid-transfer: assert reset during WDATA -> scl=1 and SDA released immediately; the next write completes normally.

Source files
------------

// File: rtl/i2c_controller.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_controller
//  Purpose  : Single-byte I2C master. A one-cycle write or read request is
//             turned into START, 6-bit address, R/W bit, address ACK, one
//             data byte (written or read), data ACK / master NACK, STOP.
//  Ports    : clk    - system clock, all state changes on its rising edge
//             reset  - asynchronous active-low reset
//             wr_en  - write request (sampled in IDLE only, wins over rd_en)
//             rd_en  - read request (sampled in IDLE only)
//             data   - write byte, captured with the request
//             addr   - target address, captured with the request
//             sda    - open-drain data line (drives 0 or releases to 'z')
//             scl    - registered I2C clock, 1 while idle
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_controller #(
   parameter int DATAWIDTH = 8,
   parameter int ADDRWIDTH = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic                 rd_en,
   input  logic [DATAWIDTH-1:0] data,
   input  logic [ADDRWIDTH-1:0] addr,
   inout  wire                  sda,
   output logic                 scl
);

   // State encoding is fixed: external benches probe state/next_state.
   localparam logic [3:0] IDLE  = 4'd0;
   localparam logic [3:0] START = 4'd1;
   localparam logic [3:0] ADDR  = 4'd2;
   localparam logic [3:0] RW    = 4'd3;
   localparam logic [3:0] ACK   = 4'd4 + 4'd1;
   localparam logic [3:0] WDATA = 4'd4;
   localparam logic [3:0] RDATA = 4'd6;
   localparam logic [3:0] DACK  = 4'd7;
   localparam logic [3:0] MNACK = 4'd8;
   localparam logic [3:0] STOP  = 4'd9;

   localparam int CNT_W = $clog2((DATAWIDTH > ADDRWIDTH) ? DATAWIDTH : ADDRWIDTH);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDRWIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATAWIDTH - 1);

   logic [3:0]           state, next_state;
   logic                 phase_q, phase_d;       // 0 = SCL low, 1 = SCL high
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [1:0]           retry_q, retry_d;
   logic [ADDRWIDTH-1:0] addr_q, addr_d;
   logic [DATAWIDTH-1:0] data_q, data_d;
   logic                 rw_q, rw_d;             // 1 = read
   logic [DATAWIDTH-1:0] rd_data_q, rd_data_d;
   logic                 nack_q, nack_d;
   logic                 scl_q, scl_d;
   logic                 sda_low_q, sda_low_d;
   logic                 sda_in;

   assign sda    = sda_low_q ? 1'b0 : 1'bz;
   assign sda_in = sda;
   assign scl    = scl_q;

   // ------------------------------------------------------------------------
   // Sequencing. Every non-idle state alternates phase each cycle and only
   // moves on at the end of its SCL-high phase, which is where SDA is sampled.
   // ------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      phase_d    = (state == IDLE) ? 1'b0 : ~phase_q;
      bit_cnt_d  = bit_cnt_q;
      retry_d    = retry_q;
      addr_d     = addr_q;
      data_d     = data_q;
      rw_d       = rw_q;
      rd_data_d  = rd_data_q;
      nack_d     = nack_q;

      case (state)
         IDLE: begin
            if (wr_en) begin
               addr_d     = addr;
               data_d     = data;
               rw_d       = 1'b0;
               nack_d     = 1'b0;
               next_state = START;
            end else if (rd_en) begin
               addr_d     = addr;
               rw_d       = 1'b1;
               nack_d     = 1'b0;
               next_state = START;
            end
         end
         START: begin
            if (phase_q) begin
               next_state = ADDR;
               bit_cnt_d  = ADDR_LAST;
            end
         end
         ADDR: begin
            if (phase_q) begin
               if (bit_cnt_q == '0) next_state = RW;
               else                 bit_cnt_d  = bit_cnt_q - 1'b1;
            end
         end
         RW: begin
            if (phase_q) begin
               next_state = ACK;
               retry_d    = 2'd0;
            end
         end
         ACK, DACK: begin
            if (phase_q) begin
               if (!sda_in) begin
                  retry_d   = 2'd0;
                  bit_cnt_d = DATA_LAST;
                  if (state == DACK) next_state = STOP;
                  else if (rw_q)     next_state = RDATA;
                  else               next_state = WDATA;
               end else if (retry_q == 2'd3) begin
                  // Fourth unanswered slot: give up and release the bus.
                  retry_d    = 2'd0;
                  nack_d     = 1'b1;
                  next_state = STOP;
               end else begin
                  retry_d = retry_q + 2'd1;
               end
            end
         end
         WDATA: begin
            if (phase_q) begin
               if (bit_cnt_q == '0) begin
                  next_state = DACK;
                  retry_d    = 2'd0;
               end else begin
                  bit_cnt_d = bit_cnt_q - 1'b1;
               end
            end
         end
         RDATA: begin
            if (phase_q) begin
               rd_data_d = {rd_data_q[DATAWIDTH-2:0], sda_in};
               if (bit_cnt_q == '0) next_state = MNACK;
               else                 bit_cnt_d  = bit_cnt_q - 1'b1;
            end
         end
         MNACK: begin
            if (phase_q) next_state = STOP;
         end
         STOP: begin
            if (phase_q) next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
            phase_d    = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Bus outputs are decoded from the *next* state/phase and registered, so
   // scl/sda change exactly on the clock edge that enters each phase.
   // ------------------------------------------------------------------------
   always_comb begin
      scl_d     = 1'b1;
      sda_low_d = 1'b0;
      case (next_state)
         IDLE: begin
            scl_d     = 1'b1;
            sda_low_d = 1'b0;
         end
         START: begin
            // First cycle SCL high with SDA low (start condition), then SCL low.
            scl_d     = ~phase_d;
            sda_low_d = 1'b1;
         end
         ADDR: begin
            scl_d     = phase_d;
            sda_low_d = ~addr_q[bit_cnt_d];
         end
         RW: begin
            scl_d     = phase_d;
            sda_low_d = ~rw_q;
         end
         WDATA: begin
            scl_d     = phase_d;
            sda_low_d = ~data_q[bit_cnt_d];
         end
         STOP: begin
            // SDA held low across both phases; IDLE releases it with SCL high.
            scl_d     = phase_d;
            sda_low_d = 1'b1;
         end
         default: begin
            // ACK, DACK, RDATA, MNACK: SDA released for the target.
            scl_d     = phase_d;
            sda_low_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         phase_q   <= 1'b0;
         bit_cnt_q <= '0;
         retry_q   <= 2'd0;
         addr_q    <= '0;
         data_q    <= '0;
         rw_q      <= 1'b0;
         rd_data_q <= '0;
         nack_q    <= 1'b0;
         scl_q     <= 1'b1;
         sda_low_q <= 1'b0;
      end else begin
         state     <= next_state;
         phase_q   <= phase_d;
         bit_cnt_q <= bit_cnt_d;
         retry_q   <= retry_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         rw_q      <= rw_d;
         rd_data_q <= rd_data_d;
         nack_q    <= nack_d;
         scl_q     <= scl_d;
         sda_low_q <= sda_low_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2c_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_controller
//  Purpose  : Self-checking bench for i2c_controller with a simple I2C
//             target model (address/data ACK, read byte driver).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] data = 8'h00;
   logic [5:0] addr = 6'h00;
   wire        sda;
   wire        scl;

   logic       ack_en = 1'b1;
   logic       tgt_rd_low = 1'b0;

   int         n_assert = 0;
   int         n_fail = 0;

   logic       exp_bits[$];
   logic       obs_bits[$];
   logic [1:0] stop_seq[$];
   int         ack_hi_cnt;
   logic       mnack_sda;
   int         start_cnt = 0;
   logic [3:0] prev_state = 4'd0;

   i2c_controller #(.DATAWIDTH(8), .ADDRWIDTH(6)) dut (
      .clk   (clk),
      .reset (reset),
      .wr_en (wr_en),
      .rd_en (rd_en),
      .data  (data),
      .addr  (addr),
      .sda   (sda),
      .scl   (scl)
   );

   pullup (sda);

   // Target: acknowledges in ACK/DACK, drives read bits when told to.
   wire tgt_low = (ack_en && (dut.state == 4'd5 || dut.state == 4'd7)) || tgt_rd_low;
   assign sda = tgt_low ? 1'b0 : 1'bz;
   wire sda_rd = (sda === 1'b0) ? 1'b0 : 1'b1;

   always #5 clk = ~clk;

   // Bits sent by the master in ADDR, RW and WDATA, captured on SCL rising.
   always @(posedge scl) begin
      #1;
      if (dut.state == 4'd2 || dut.state == 4'd3 || dut.state == 4'd4)
         obs_bits.push_back(sda_rd);
   end

   always @(negedge clk) begin
      if (dut.state == 4'd1 && prev_state != 4'd1) start_cnt++;
      prev_state = dut.state;
   end

   task automatic push_exp(input logic [5:0] a, input logic rw, input logic [7:0] d,
                           input bit with_data);
      exp_bits.delete();
      for (int i = 5; i >= 0; i--) exp_bits.push_back(a[i]);
      exp_bits.push_back(rw);
      if (with_data) for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
   endtask

   function automatic logic [15:0] drain_obs();
      logic [15:0] v = '0;
      while (obs_bits.size() > 0) v = {v[14:0], obs_bits.pop_front()};
      return v;
   endfunction

   function automatic logic [15:0] drain_exp();
      logic [15:0] v = '0;
      while (exp_bits.size() > 0) v = {v[14:0], exp_bits.pop_front()};
      return v;
   endfunction

   task automatic issue(input logic w, input logic r, input logic [5:0] a, input logic [7:0] d);
      wr_en = w; rd_en = r; addr = a; data = d;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic run_until_idle(output int cycles);
      int n = 0;
      stop_seq.delete();
      ack_hi_cnt = 0;
      mnack_sda  = 1'bx;
      while (dut.state != 4'd0 && n < 400) begin
         @(posedge clk); #1;
         n++;
         if (dut.state == 4'd9) stop_seq.push_back({scl, sda_rd});
         if ((dut.state == 4'd5 || dut.state == 4'd7) && scl === 1'b1) ack_hi_cnt++;
         if (dut.state == 4'd8 && scl === 1'b1) mnack_sda = sda_rd;
      end
      cycles = n;
      n_assert++;
      if (dut.state != 4'd0) begin
         n_fail++;
         $display("FAIL idle_timeout: state %0d after %0d cycles, required 0", dut.state, n);
      end
   endtask

   task automatic drive_read_byte(input logic [7:0] b);
      int g = 0;
      while (dut.state != 4'd6 && g < 200) begin @(negedge clk); g++; end
      for (int i = 7; i >= 0; i--) begin
         tgt_rd_low = ~b[i];
         g = 0;
         while (scl !== 1'b1 && g < 10) begin @(negedge clk); g++; end
         g = 0;
         while (scl !== 1'b0 && g < 10) begin @(negedge clk); g++; end
      end
      tgt_rd_low = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_assert++; if (dut.state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d, required 0", dut.state); end
      n_assert++; if (scl !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b, required 1", scl); end
      n_assert++; if (sda_rd !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b, required 1", sda_rd); end
      n_assert++; if (dut.rd_data_q !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h, required 00", dut.rd_data_q); end
      n_assert++; if (dut.nack_q !== 1'b0) begin n_fail++; $display("FAIL reset_nack: got %b, required 0", dut.nack_q); end
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_assert++; if (dut.state !== 4'd0 || scl !== 1'b1) begin n_fail++; $display("FAIL idle_hold: state %0d scl %b, required 0/1", dut.state, scl); end
   endtask

   task automatic test_write();
      int cyc, on, en;
      logic [15:0] ov, ev;
      ack_en = 1'b1;
      obs_bits.delete();
      push_exp(6'h2A, 1'b0, 8'hC5, 1'b1);
      issue(1'b1, 1'b0, 6'h2A, 8'hC5);
      n_assert++; if (dut.state !== 4'd1) begin n_fail++; $display("FAIL write_accept: state %0d, required 1", dut.state); end
      run_until_idle(cyc);
      n_assert++; if (cyc != 38) begin n_fail++; $display("FAIL write_len: got %0d cycles, required 38", cyc); end
      on = obs_bits.size(); en = exp_bits.size(); ov = drain_obs(); ev = drain_exp();
      n_assert++; if (on != en || ov !== ev) begin n_fail++; $display("FAIL write_bits: got %0d bits %b, required %0d bits %b", on, ov, en, ev); end
      n_assert++; if (stop_seq.size() != 2 || stop_seq[0] !== 2'b00 || stop_seq[1] !== 2'b10) begin n_fail++; $display("FAIL write_stop: got %0d steps, required scl/sda 00 then 10", stop_seq.size()); end
      n_assert++; if (scl !== 1'b1 || sda_rd !== 1'b1) begin n_fail++; $display("FAIL write_release: scl %b sda %b, required 1/1", scl, sda_rd); end
      n_assert++; if (dut.nack_q !== 1'b0) begin n_fail++; $display("FAIL write_nack: got %b, required 0", dut.nack_q); end
   endtask

   task automatic test_read();
      int cyc, on, en;
      logic [15:0] ov, ev;
      ack_en = 1'b1;
      obs_bits.delete();
      push_exp(6'h15, 1'b1, 8'h00, 1'b0);
      issue(1'b0, 1'b1, 6'h15, 8'h00);
      fork
         run_until_idle(cyc);
         drive_read_byte(8'h3C);
      join
      n_assert++; if (cyc != 38) begin n_fail++; $display("FAIL read_len: got %0d cycles, required 38", cyc); end
      on = obs_bits.size(); en = exp_bits.size(); ov = drain_obs(); ev = drain_exp();
      n_assert++; if (on != en || ov !== ev) begin n_fail++; $display("FAIL read_addr_rw: got %0d bits %b, required %0d bits %b", on, ov, en, ev); end
      n_assert++; if (dut.rd_data_q !== 8'h3C) begin n_fail++; $display("FAIL read_data: got %h, required 3c", dut.rd_data_q); end
      n_assert++; if (mnack_sda !== 1'b1) begin n_fail++; $display("FAIL read_mnack: sda %b, required 1", mnack_sda); end
      n_assert++; if (stop_seq.size() != 2 || stop_seq[0] !== 2'b00 || stop_seq[1] !== 2'b10) begin n_fail++; $display("FAIL read_stop: got %0d steps, required scl/sda 00 then 10", stop_seq.size()); end
   endtask

   task automatic test_no_ack();
      int cyc, on, en;
      logic [15:0] ov, ev;
      ack_en = 1'b0;
      obs_bits.delete();
      push_exp(6'h01, 1'b0, 8'hFF, 1'b0);
      issue(1'b1, 1'b0, 6'h01, 8'hFF);
      run_until_idle(cyc);
      ack_en = 1'b1;
      n_assert++; if (cyc != 26) begin n_fail++; $display("FAIL noack_len: got %0d cycles, required 26", cyc); end
      n_assert++; if (ack_hi_cnt != 4) begin n_fail++; $display("FAIL noack_slots: got %0d, required 4", ack_hi_cnt); end
      n_assert++; if (dut.nack_q !== 1'b1) begin n_fail++; $display("FAIL noack_flag: got %b, required 1", dut.nack_q); end
      on = obs_bits.size(); en = exp_bits.size(); ov = drain_obs(); ev = drain_exp();
      n_assert++; if (on != en || ov !== ev) begin n_fail++; $display("FAIL noack_bits: got %0d bits %b, required %0d bits %b", on, ov, en, ev); end
      n_assert++; if (stop_seq.size() != 2 || stop_seq[0] !== 2'b00 || stop_seq[1] !== 2'b10) begin n_fail++; $display("FAIL noack_stop: got %0d steps, required scl/sda 00 then 10", stop_seq.size()); end
   endtask

   task automatic test_busy();
      int cyc, on, en, s0;
      logic [15:0] ov, ev;
      obs_bits.delete();
      push_exp(6'h33, 1'b0, 8'hA6, 1'b1);
      s0 = start_cnt;
      wr_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         addr = 6'h33 + 6'(i);
         data = 8'hA6 + 8'(i);
         @(posedge clk); #1;
         if (i == 0) begin
            n_assert++; if (dut.nack_q !== 1'b0) begin n_fail++; $display("FAIL busy_nack_clear: got %b, required 0", dut.nack_q); end
         end
      end
      wr_en = 1'b0;
      run_until_idle(cyc);
      n_assert++; if (cyc != 29) begin n_fail++; $display("FAIL busy_len: got %0d cycles, required 29", cyc); end
      on = obs_bits.size(); en = exp_bits.size(); ov = drain_obs(); ev = drain_exp();
      n_assert++; if (on != en || ov !== ev) begin n_fail++; $display("FAIL busy_bits: got %0d bits %b, required %0d bits %b", on, ov, en, ev); end
      repeat (3) @(posedge clk);
      #1;
      n_assert++; if (start_cnt - s0 != 1 || dut.state !== 4'd0) begin n_fail++; $display("FAIL busy_count: got %0d transactions state %0d, required 1 and 0", start_cnt - s0, dut.state); end
   endtask

   task automatic test_priority();
      int cyc, on, en;
      logic [15:0] ov, ev;
      obs_bits.delete();
      push_exp(6'h0C, 1'b0, 8'h5A, 1'b1);
      issue(1'b1, 1'b1, 6'h0C, 8'h5A);
      run_until_idle(cyc);
      n_assert++; if (cyc != 38) begin n_fail++; $display("FAIL prio_len: got %0d cycles, required 38", cyc); end
      on = obs_bits.size(); en = exp_bits.size(); ov = drain_obs(); ev = drain_exp();
      n_assert++; if (on != en || ov !== ev) begin n_fail++; $display("FAIL prio_bits: got %0d bits %b, required %0d bits %b", on, ov, en, ev); end
   endtask

   task automatic test_back_to_back();
      int cyc, on, en;
      logic [15:0] ov, ev;
      obs_bits.delete();
      push_exp(6'h3F, 1'b0, 8'h81, 1'b1);
      issue(1'b1, 1'b0, 6'h3F, 8'h81);
      run_until_idle(cyc);
      on = obs_bits.size(); en = exp_bits.size(); ov = drain_obs(); ev = drain_exp();
      n_assert++; if (on != en || ov !== ev) begin n_fail++; $display("FAIL b2b_first_bits: got %0d bits %b, required %0d bits %b", on, ov, en, ev); end
      // Request already waiting in the first IDLE cycle.
      push_exp(6'h2B, 1'b0, 8'h7E, 1'b1);
      issue(1'b1, 1'b0, 6'h2B, 8'h7E);
      n_assert++; if (dut.state !== 4'd1) begin n_fail++; $display("FAIL b2b_accept: state %0d, required 1", dut.state); end
      run_until_idle(cyc);
      n_assert++; if (cyc != 38) begin n_fail++; $display("FAIL b2b_len: got %0d cycles, required 38", cyc); end
      on = obs_bits.size(); en = exp_bits.size(); ov = drain_obs(); ev = drain_exp();
      n_assert++; if (on != en || ov !== ev) begin n_fail++; $display("FAIL b2b_second_bits: got %0d bits %b, required %0d bits %b", on, ov, en, ev); end
   endtask

   task automatic test_reset_mid();
      int cyc, on, en, g;
      logic [15:0] ov, ev;
      issue(1'b1, 1'b0, 6'h2A, 8'hC5);
      g = 0;
      while (dut.state != 4'd4 && g < 100) begin @(posedge clk); #1; g++; end
      n_assert++; if (dut.state !== 4'd4) begin n_fail++; $display("FAIL mid_reach_wdata: state %0d, required 4", dut.state); end
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      n_assert++; if (scl !== 1'b1 || sda_rd !== 1'b1 || dut.state !== 4'd0) begin n_fail++; $display("FAIL mid_reset_bus: scl %b sda %b state %0d, required 1/1/0", scl, sda_rd, dut.state); end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      obs_bits.delete();
      push_exp(6'h11, 1'b0, 8'h96, 1'b1);
      issue(1'b1, 1'b0, 6'h11, 8'h96);
      run_until_idle(cyc);
      n_assert++; if (cyc != 38) begin n_fail++; $display("FAIL mid_next_len: got %0d cycles, required 38", cyc); end
      on = obs_bits.size(); en = exp_bits.size(); ov = drain_obs(); ev = drain_exp();
      n_assert++; if (on != en || ov !== ev) begin n_fail++; $display("FAIL mid_next_bits: got %0d bits %b, required %0d bits %b", on, ov, en, ev); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_no_ack();
      test_busy();
      test_priority();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
